// File: rtl/apb_master_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the APB slave side.
// Requester i occupies slice i of every packed request/response field.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SEL_WIDTH
`define SEL_WIDTH 2
`endif

interface apb_master_arbiter_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int SEL_WIDTH  = `SEL_WIDTH
);
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*SEL_WIDTH-1:0]  req_sel;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [SEL_WIDTH-1:0]    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_sel,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_sel,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Bad selects short-circuit to an error response; stuck slaves time out.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SEL_WIDTH
`define SEL_WIDTH 2
`endif

module apb_master_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int SEL_WIDTH  = `SEL_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input logic main_clk,
  input logic main_rsn,
  apb_master_arbiter_if.master bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  last_q;
  logic                  own_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  gidx;
  logic                  accept;
  logic [SEL_WIDTH-1:0]  sel_in;
  logic                  sel_ok;
  logic                  tmo_hit;

  // Round-robin pick; only offered in IDLE and never while reset is held.
  always_comb begin
    gidx   = 1'b0;
    accept = 1'b0;
    bus.req_ready = 2'b00;
    if (&bus.req_valid) gidx = ~last_q;
    else                gidx = bus.req_valid[1];
    if (state_q == IDLE && !main_rsn && |bus.req_valid) begin
      accept        = 1'b1;
      bus.req_ready = 2'b01 << gidx;
    end
    sel_in = bus.req_sel[gidx*SEL_WIDTH +: SEL_WIDTH];
    sel_ok = $onehot(sel_in);
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge main_clk or posedge main_rsn) begin
    if (main_rsn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and bus/response outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    bus.psel      = '0;
    bus.penable   = 1'b0;
    bus.rsp_valid = 2'b00;
    bus.rsp_err   = 2'b00;
    bus.pwrite    = wr_q;
    bus.paddr     = addr_q;
    bus.pwdata    = wdata_q;
    bus.rsp_rdata = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = sel_ok ? SETUP : ERR;
      end
      SETUP: begin
        bus.psel = sel_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        bus.psel    = sel_q;
        bus.penable = 1'b1;
        if (bus.pready || tmo_hit) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 2'b01 << own_q;
        bus.rsp_err   = {2{err_q}} & (2'b01 << own_q);
        state_d       = IDLE;
      end
      ERR: begin
        bus.rsp_valid = 2'b01 << own_q;
        bus.rsp_err   = 2'b01 << own_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and response payload.
  always_ff @(posedge main_clk or posedge main_rsn) begin
    if (main_rsn) begin
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        last_q  <= gidx;
        own_q   <= gidx;
        addr_q  <= bus.req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= bus.req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
        wr_q    <= bus.req_write[gidx];
        sel_q   <= sel_in;
        if (!sel_ok) rdata_q <= '0;
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS) begin
        if (bus.pready) begin
          err_q   <= bus.pslverr;
          rdata_q <= wr_q ? '0 : bus.prdata;
        end else if (tmo_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench: two requesters and a reactive APB slave, checked per
// cycle against a transaction-level timeline model.
module tb_apb_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 2;
  localparam int TO = 4;

  logic main_clk = 1'b0;
  logic main_rsn;

  always #5 main_clk = ~main_clk;

  apb_master_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)
  ) bus ();

  apb_master_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .main_clk(main_clk),
    .main_rsn(main_rsn),
    .bus(bus.master)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester side
  bit          pend[2];
  bit          wait_rsp[2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_wdata[2];
  bit          r_wr[2];
  logic [SW-1:0] r_sel[2];

  // current transfer timeline
  bit          act;
  int          t0, n, own, w;
  bit          bad, exp_err;
  logic [DW-1:0] exp_rd, prd;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  bit          c_wr, slv;
  logic [SW-1:0] c_sel;
  int          free_at, cyc;
  bit          last;
  logic [DW-1:0] hold_rd;

  // reactive slave
  bit cur_pen;
  int acc_idx, acc_run;

  task automatic new_req(int i);
    logic [SW-1:0] pick[6];
    pick[0] = 2'b01; pick[1] = 2'b10; pick[2] = 2'b01;
    pick[3] = 2'b10; pick[4] = 2'b00; pick[5] = 2'b11;
    r_addr[i]  = AW'($urandom);
    r_wdata[i] = $urandom;
    r_wr[i]    = 1'($urandom);
    r_sel[i]   = pick[$urandom_range(0, 5)];
    pend[i]    = 1'b1;
  endtask

  task automatic drive_cycle();
    logic [1:0] exp_rdy;
    int g;
    @(negedge main_clk);
    for (int i = 0; i < 2; i++)
      if (!pend[i] && !wait_rsp[i] && $urandom_range(0, 2) != 0)
        new_req(i);
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = r_wr[i];
      bus.req_addr[i*AW +: AW]  = r_addr[i];
      bus.req_wdata[i*DW +: DW] = r_wdata[i];
      bus.req_sel[i*SW +: SW]   = r_sel[i];
    end
    bus.pready  = cur_pen ? (acc_idx >= w) : 1'($urandom);
    bus.prdata  = cur_pen ? prd : $urandom;
    bus.pslverr = cur_pen ? slv : 1'($urandom);
    #1;
    exp_rdy = 2'b00;
    if (cyc >= free_at) begin
      if (pend[0] && pend[1]) exp_rdy = last ? 2'b01 : 2'b10;
      else if (pend[0])       exp_rdy = 2'b01;
      else if (pend[1])       exp_rdy = 2'b10;
    end
    chk("req_ready", bus.req_ready, exp_rdy);
    if (exp_rdy != 2'b00) begin
      g = exp_rdy[1] ? 1 : 0;
      last = g[0];
      pend[g] = 1'b0;
      wait_rsp[g] = 1'b1;
      act = 1'b1;
      t0 = cyc;
      own = g;
      c_addr = r_addr[g];
      c_wdata = r_wdata[g];
      c_wr = r_wr[g];
      c_sel = r_sel[g];
      bad = !$onehot(c_sel);
      w = $urandom_range(0, 6);
      prd = $urandom;
      slv = ($urandom_range(0, 3) == 0);
      if (bad) begin
        n = 0;
        exp_err = 1'b1;
        exp_rd = '0;
        free_at = cyc + 2;
      end else begin
        n = (w >= TO) ? TO : w + 1;
        exp_err = (w >= TO) || slv;
        exp_rd = (!c_wr && w < TO) ? prd : '0;
        free_at = cyc + 3 + n;
      end
    end
  endtask

  task automatic post_edge();
    int k;
    logic [SW-1:0] e_psel;
    bit e_pen;
    logic [1:0] e_rv, e_err;
    @(posedge main_clk);
    #1;
    cyc++;
    k = cyc - t0;
    e_psel = '0;
    e_pen = 1'b0;
    e_rv = 2'b00;
    e_err = 2'b00;
    if (act) begin
      if (bad) begin
        if (k == 1) begin
          e_rv = 2'b01 << own;
          e_err = e_rv;
          hold_rd = '0;
          act = 1'b0;
          wait_rsp[own] = 1'b0;
        end
      end else begin
        if (k >= 1 && k <= 1 + n) e_psel = c_sel;
        if (k >= 2 && k <= 1 + n) e_pen = 1'b1;
        if (k == 2 + n) begin
          e_rv = 2'b01 << own;
          e_err = exp_err ? e_rv : 2'b00;
          hold_rd = exp_rd;
          act = 1'b0;
          wait_rsp[own] = 1'b0;
        end
      end
    end
    chk("psel", bus.psel, e_psel);
    chk("penable", bus.penable, e_pen);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_err", bus.rsp_err, e_err);
    chk("rsp_rdata", bus.rsp_rdata, hold_rd);
    if (e_psel != '0)
      chk("apb_fields", {bus.pwrite, bus.paddr, bus.pwdata},
          {c_wr, c_addr, c_wdata});
    cur_pen = bus.penable;
    if (bus.penable) begin
      acc_idx = acc_run;
      acc_run++;
    end else begin
      acc_run = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      wait_rsp[i] = 1'b0;
    end
    act = 1'b0;
    last = 1'b1;
    free_at = 0;
    cyc = 0;
    t0 = 0;
    hold_rd = '0;
    cur_pen = 1'b0;
    acc_run = 0;
    acc_idx = 0;
    w = 0;
  endtask

  initial begin
    int guard;
    model_reset();
    main_rsn = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_write = 2'b11;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_sel   = {2'b10, 2'b01};
    bus.prdata    = '1;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr,
                    bus.pwdata}, '0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, '0);
    @(negedge main_clk);
    bus.req_valid = 2'b00;
    main_rsn = 1'b0;

    repeat (800) begin
      drive_cycle();
      post_edge();
    end

    guard = 0;
    while (!cur_pen && guard < 200) begin
      drive_cycle();
      post_edge();
      guard++;
    end
    chk("reach_access", cur_pen, 1'b1);
    @(negedge main_clk);
    #2 main_rsn = 1'b1;
    #1;
    chk("rst_mid_psel", bus.psel, '0);
    chk("rst_mid_pen", bus.penable, 1'b0);
    chk("rst_mid_rsp", bus.rsp_valid, 2'b00);
    bus.req_valid = 2'b00;
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    main_rsn = 1'b0;
    model_reset();
    new_req(0);
    new_req(1);
    drive_cycle();
    chk("post_rst_grant", bus.req_ready, 2'b01);
    post_edge();

    repeat (300) begin
      drive_cycle();
      post_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, meaning APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, meaning APB address width.
REQ-003 SHALL have parameter SEL_WIDTH, default `SEL_WIDTH, meaning number of one-hot PSEL lines.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning max ACCESS cycles without PREADY; 0 disables.
REQ-005 SHALL have port main_clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port main_rsn, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have req_valid, req_write: input, 2; per-requester request and direction (1=write).
REQ-008 SHALL have req_addr, input, 2*ADDR_WIDTH; req_wdata, input, 2*DATA_WIDTH; req_sel, input, 2*SEL_WIDTH; requester i in slice i.
REQ-009 SHALL have req_ready, output, 2, per-requester accept strobe.
REQ-010 SHALL have rsp_valid, output, 2; rsp_err, output, 2; rsp_rdata, output, DATA_WIDTH; completion to the owning requester.
REQ-011 SHALL have APB master ports psel (SEL_WIDTH), penable, pwrite, paddr (ADDR_WIDTH), pwdata (DATA_WIDTH) outputs; prdata (DATA_WIDTH), pready, pslverr inputs.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, ERR.
REQ-013 SHALL, in IDLE only, assert req_ready combinationally for exactly one requester with req_valid=1; acceptance = req_valid & req_ready.
REQ-014 SHALL arbitrate round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last_grant updates on acceptance.
REQ-015 SHALL register addr, wdata, write, sel, owner on acceptance; requester inputs ignored until its response.
REQ-016 SHALL, on acceptance with one-hot req_sel, go to SETUP: psel=captured sel, penable=0, paddr/pwrite/pwdata=captured values.
REQ-017 SHALL, on acceptance with zero or multi-hot req_sel, go to ERR: no APB activity; psel stays 0.
REQ-018 SHALL go SETUP -> ACCESS unconditionally after one cycle; penable=1 in ACCESS; psel/paddr/pwrite/pwdata stable through SETUP and ACCESS.
REQ-019 SHALL, in ACCESS with pready=1, capture prdata (reads only, else 0) and pslverr, go to RESP, deassert psel and penable next cycle.
REQ-020 SHALL count ACCESS cycles with pready=0; when TIMEOUT!=0 and count reaches TIMEOUT, go to RESP with err=1, rdata=0, psel/penable dropped.
REQ-021 SHALL, in RESP and ERR, pulse rsp_valid[owner] for exactly one cycle with rsp_err, rsp_rdata; ERR forces rsp_err=1, rdata=0; then IDLE.
REQ-022 SHALL hold rsp_rdata until next response; rsp_valid, rsp_err 0 outside RESP/ERR.
REQ-023 SHALL give latency: accept at cycle t, pready=1 at first ACCESS cycle -> SETUP t+1, ACCESS t+2, rsp_valid t+3; next accept no earlier than t+4.
REQ-024 SHALL clear the timeout counter on entry to ACCESS.

Reset
REQ-025 SHALL, while main_rsn=1, immediately force state IDLE, last_grant=1 (requester 0 first), counter 0, all outputs 0.
REQ-026 SHALL, on reset mid-transfer, drop psel/penable asynchronously and issue no response for the aborted transfer.

Verification
REQ-027 Write: req0 addr 0x10, wdata 0xA5, sel 0b01, pready=1 -> SETUP t+1, ACCESS t+2 penable=1, rsp_valid[0]=1, rsp_err=0 at t+3.
REQ-028 Read with wait: req1 read, pready low 3 ACCESS cycles, prdata=0x3C -> psel held 4 ACCESS cycles; rsp_valid[1], rsp_rdata=0x3C.
REQ-029 Contention: both valid continuously after reset -> grants 0,1,0,1; never both req_ready high.
REQ-030 Timeout: TIMEOUT=4, pready stuck 0 -> exactly 4 ACCESS cycles, then rsp_err=1, rdata=0, psel=0.
REQ-031 Bad select: req_sel=0b11 -> no psel activity, rsp_valid with rsp_err=1 one cycle after accept; pslverr=1 on a valid transfer -> rsp_err=1.
REQ-032 Reset during ACCESS -> psel, penable, rsp_valid 0 immediately; after release, requester 0 granted first.
